// File: rtl/e203_exu_oitf.sv
// Outstanding instruction tracking FIFO for long-pipe instructions: in-order alloc/retire plus
// destination hazard matching against the dispatching instruction. Optional macro: E203_OITF_FPU_EN.

module e203_exu_oitf_entry #(
   parameter int RFIDX_W = 5,
   parameter int PC_W    = 32
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    set,
   input  logic                    clr,
   input  logic [RFIDX_W-1:0]      wr_rdidx,
   input  logic                    wr_rdwen,
   input  logic                    wr_rdfpu,
   input  logic [PC_W-1:0]         wr_pc,
   input  logic [3:0][RFIDX_W-1:0] cmp_idx,
   input  logic [3:0]              cmp_fpu,
   output logic                    vld,
   output logic [RFIDX_W-1:0]      rdidx,
   output logic                    rdwen,
   output logic                    rdfpu,
   output logic [PC_W-1:0]         pc,
   output logic [3:0]              hit
);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld   <= 1'b0;
         rdidx <= '0;
         rdwen <= 1'b0;
         pc    <= '0;
      end else if (set) begin
         vld   <= 1'b1;
         rdidx <= wr_rdidx;
         rdwen <= wr_rdwen;
         pc    <= wr_pc;
      end else if (clr) begin
         vld   <= 1'b0;
      end
   end

`ifdef E203_OITF_FPU_EN
   always_ff @(posedge clk) begin
      if (!rst_n)   rdfpu <= 1'b0;
      else if (set) rdfpu <= wr_rdfpu;
   end

   for (genvar k = 0; k < 4; k++) begin : g_hit
      assign hit[k] = vld & rdwen & (rdidx == cmp_idx[k]) & (rdfpu == cmp_fpu[k]);
   end
`else
   // Integer-only build: fpu tags are neither stored nor compared.
   logic unused_fpu;
   assign unused_fpu = ^{wr_rdfpu, cmp_fpu};
   assign rdfpu      = 1'b0;

   for (genvar k = 0; k < 4; k++) begin : g_hit
      assign hit[k] = vld & rdwen & (rdidx == cmp_idx[k]);
   end
`endif

endmodule

module e203_exu_oitf #(
   parameter int OITF_DEPTH = 2,
   parameter int ITAG_W     = 1,
   parameter int RFIDX_W    = 5,
   parameter int PC_W       = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   output logic               dis_ready,
   input  logic               dis_ena,
   output logic [ITAG_W-1:0]  dis_ptr,
   input  logic               disp_i_rdwen,
   input  logic               disp_i_rdfpu,
   input  logic [RFIDX_W-1:0] disp_i_rdidx,
   input  logic [PC_W-1:0]    disp_i_pc,
   input  logic               disp_i_rs1en,
   input  logic               disp_i_rs2en,
   input  logic               disp_i_rs3en,
   input  logic               disp_i_rs1fpu,
   input  logic               disp_i_rs2fpu,
   input  logic               disp_i_rs3fpu,
   input  logic [RFIDX_W-1:0] disp_i_rs1idx,
   input  logic [RFIDX_W-1:0] disp_i_rs2idx,
   input  logic [RFIDX_W-1:0] disp_i_rs3idx,
   input  logic               ret_ena,
   output logic [ITAG_W-1:0]  ret_ptr,
   output logic [RFIDX_W-1:0] ret_rdidx,
   output logic               ret_rdwen,
   output logic               ret_rdfpu,
   output logic [PC_W-1:0]    ret_pc,
   output logic               oitf_empty,
   output logic               oitfrd_match_disprs1,
   output logic               oitfrd_match_disprs2,
   output logic               oitfrd_match_disprs3,
   output logic               oitfrd_match_disprd
);

   logic [ITAG_W-1:0] alloc_ptr, rtr_ptr;
   logic              alloc_flg, rtr_flg;
   logic              full, empty, alloc_go, rtr_go;

   assign full     = (alloc_ptr == rtr_ptr) & (alloc_flg != rtr_flg);
   assign empty    = (alloc_ptr == rtr_ptr) & (alloc_flg == rtr_flg);
   assign alloc_go = dis_ena & ~full;
   assign rtr_go   = ret_ena & ~empty;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         alloc_ptr <= '0;
         alloc_flg <= 1'b0;
         rtr_ptr   <= '0;
         rtr_flg   <= 1'b0;
      end else begin
         if (alloc_go) begin
            if (alloc_ptr == ITAG_W'(OITF_DEPTH-1)) begin
               alloc_ptr <= '0;
               alloc_flg <= ~alloc_flg;
            end else begin
               alloc_ptr <= alloc_ptr + ITAG_W'(1);
            end
         end
         if (rtr_go) begin
            if (rtr_ptr == ITAG_W'(OITF_DEPTH-1)) begin
               rtr_ptr <= '0;
               rtr_flg <= ~rtr_flg;
            end else begin
               rtr_ptr <= rtr_ptr + ITAG_W'(1);
            end
         end
      end
   end

   // Compare slots: 0=rs1, 1=rs2, 2=rs3, 3=rd.
   logic [3:0][RFIDX_W-1:0]            cmp_idx;
   logic [3:0]                         cmp_fpu, cmp_en, any_hit;
   logic [OITF_DEPTH-1:0][3:0]         ent_hit;
   logic [OITF_DEPTH-1:0]              ent_vld, ent_rdwen, ent_rdfpu;
   logic [OITF_DEPTH-1:0][RFIDX_W-1:0] ent_rdidx;
   logic [OITF_DEPTH-1:0][PC_W-1:0]    ent_pc;

   assign cmp_idx = {disp_i_rdidx, disp_i_rs3idx, disp_i_rs2idx, disp_i_rs1idx};
   assign cmp_fpu = {disp_i_rdfpu, disp_i_rs3fpu, disp_i_rs2fpu, disp_i_rs1fpu};
   assign cmp_en  = {disp_i_rdwen, disp_i_rs3en,  disp_i_rs2en,  disp_i_rs1en};

   for (genvar e = 0; e < OITF_DEPTH; e++) begin : g_ent
      e203_exu_oitf_entry #(.RFIDX_W(RFIDX_W), .PC_W(PC_W)) u_ent (
         .clk      (clk),
         .rst_n    (rst_n),
         .set      (alloc_go & (alloc_ptr == ITAG_W'(e))),
         .clr      (rtr_go & (rtr_ptr == ITAG_W'(e))),
         .wr_rdidx (disp_i_rdidx),
         .wr_rdwen (disp_i_rdwen),
         .wr_rdfpu (disp_i_rdfpu),
         .wr_pc    (disp_i_pc),
         .cmp_idx  (cmp_idx),
         .cmp_fpu  (cmp_fpu),
         .vld      (ent_vld[e]),
         .rdidx    (ent_rdidx[e]),
         .rdwen    (ent_rdwen[e]),
         .rdfpu    (ent_rdfpu[e]),
         .pc       (ent_pc[e]),
         .hit      (ent_hit[e])
      );
   end

   always_comb begin
      any_hit = '0;
      for (int e = 0; e < OITF_DEPTH; e++) any_hit = any_hit | ent_hit[e];
   end

   assign oitfrd_match_disprs1 = any_hit[0] & cmp_en[0];
   assign oitfrd_match_disprs2 = any_hit[1] & cmp_en[1];
   assign oitfrd_match_disprs3 = any_hit[2] & cmp_en[2];
   assign oitfrd_match_disprd  = any_hit[3] & cmp_en[3];

   logic unused_vld;
   assign unused_vld = ^ent_vld;

   assign dis_ready  = ~full;
   assign dis_ptr    = alloc_ptr;
   assign ret_ptr    = rtr_ptr;
   assign oitf_empty = empty;
   assign ret_rdidx  = ent_rdidx[rtr_ptr];
   assign ret_rdwen  = ent_rdwen[rtr_ptr];
   assign ret_rdfpu  = ent_rdfpu[rtr_ptr];
   assign ret_pc     = ent_pc[rtr_ptr];

endmodule

// File: tb/tb_e203_exu_oitf.sv
// Directed bench for e203_exu_oitf (DEPTH=2, default integer-only build).

module tb_e203_exu_oitf;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        dis_ready, dis_ena;
   logic [0:0]  dis_ptr, ret_ptr;
   logic        disp_i_rdwen, disp_i_rdfpu;
   logic [4:0]  disp_i_rdidx;
   logic [31:0] disp_i_pc;
   logic        disp_i_rs1en, disp_i_rs2en, disp_i_rs3en;
   logic        disp_i_rs1fpu, disp_i_rs2fpu, disp_i_rs3fpu;
   logic [4:0]  disp_i_rs1idx, disp_i_rs2idx, disp_i_rs3idx;
   logic        ret_ena;
   logic [4:0]  ret_rdidx;
   logic        ret_rdwen, ret_rdfpu;
   logic [31:0] ret_pc;
   logic        oitf_empty;
   logic        m_rs1, m_rs2, m_rs3, m_rd;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   e203_exu_oitf #(.OITF_DEPTH(2), .ITAG_W(1), .RFIDX_W(5), .PC_W(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .dis_ready(dis_ready), .dis_ena(dis_ena), .dis_ptr(dis_ptr),
      .disp_i_rdwen(disp_i_rdwen), .disp_i_rdfpu(disp_i_rdfpu),
      .disp_i_rdidx(disp_i_rdidx), .disp_i_pc(disp_i_pc),
      .disp_i_rs1en(disp_i_rs1en), .disp_i_rs2en(disp_i_rs2en), .disp_i_rs3en(disp_i_rs3en),
      .disp_i_rs1fpu(disp_i_rs1fpu), .disp_i_rs2fpu(disp_i_rs2fpu), .disp_i_rs3fpu(disp_i_rs3fpu),
      .disp_i_rs1idx(disp_i_rs1idx), .disp_i_rs2idx(disp_i_rs2idx), .disp_i_rs3idx(disp_i_rs3idx),
      .ret_ena(ret_ena), .ret_ptr(ret_ptr), .ret_rdidx(ret_rdidx), .ret_rdwen(ret_rdwen),
      .ret_rdfpu(ret_rdfpu), .ret_pc(ret_pc), .oitf_empty(oitf_empty),
      .oitfrd_match_disprs1(m_rs1), .oitfrd_match_disprs2(m_rs2),
      .oitfrd_match_disprs3(m_rs3), .oitfrd_match_disprd(m_rd)
   );

   // Status vector: {empty, ready, dis_ptr, ret_ptr}
   logic [3:0] st;
   assign st = {oitf_empty, dis_ready, dis_ptr, ret_ptr};
   logic [3:0] mt;
   assign mt = {m_rs1, m_rs2, m_rs3, m_rd};

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_inputs();
      dis_ena = 0; ret_ena = 0;
      disp_i_rdwen = 0; disp_i_rdfpu = 0; disp_i_rdidx = 0; disp_i_pc = 0;
      disp_i_rs1en = 0; disp_i_rs2en = 0; disp_i_rs3en = 0;
      disp_i_rs1fpu = 0; disp_i_rs2fpu = 0; disp_i_rs3fpu = 0;
      disp_i_rs1idx = 0; disp_i_rs2idx = 0; disp_i_rs3idx = 0;
   endtask

   task automatic do_reset();
      clr_inputs();
      rst_n = 0;
      step(); step();
      rst_n = 1;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (st !== 4'b1100) begin errors++; $display("FAIL reset_status got %b exp 1100", st); end
      checks++;
      if ({ret_rdidx, ret_rdwen, ret_rdfpu, ret_pc} !== 39'h0) begin
         errors++; $display("FAIL reset_payload got %h exp 0", {ret_rdidx, ret_rdwen, ret_rdfpu, ret_pc});
      end
      disp_i_rs1en = 1; disp_i_rs2en = 1; disp_i_rs3en = 1; disp_i_rdwen = 1; #1;
      checks++;
      if (mt !== 4'b0000) begin errors++; $display("FAIL reset_match got %b exp 0000", mt); end
      clr_inputs();
   endtask

   task automatic test_alloc();
      do_reset();
      dis_ena = 1; disp_i_rdidx = 5; disp_i_rdwen = 1; disp_i_pc = 32'h80;
      step();
      dis_ena = 0;
      checks++;
      if (st !== 4'b0110) begin errors++; $display("FAIL alloc_status got %b exp 0110", st); end
      checks++;
      if ({ret_rdidx, ret_rdwen, ret_pc} !== {5'd5, 1'b1, 32'h80}) begin
         errors++; $display("FAIL alloc_payload got %0d/%0d/%h exp 5/1/80", ret_rdidx, ret_rdwen, ret_pc);
      end
   endtask

   // continues from test_alloc: one entry held
   task automatic test_full();
      dis_ena = 1; disp_i_rdidx = 6; disp_i_pc = 32'h84;
      step();
      checks++;
      if (st !== 4'b0000) begin errors++; $display("FAIL full_status got %b exp 0000", st); end
      disp_i_rdidx = 9; disp_i_pc = 32'h88; ret_ena = 1;
      step();
      dis_ena = 0;
      checks++;
      if (st !== 4'b0101) begin errors++; $display("FAIL full_blocked got %b exp 0101", st); end
      checks++;
      if ({ret_rdidx, ret_pc} !== {5'd6, 32'h84}) begin
         errors++; $display("FAIL full_head got %0d/%h exp 6/84", ret_rdidx, ret_pc);
      end
      step();
      ret_ena = 0;
      checks++;
      if (st !== 4'b1100) begin errors++; $display("FAIL full_drain got %b exp 1100", st); end
      checks++;
      if ({ret_rdidx, ret_pc} !== {5'd5, 32'h80}) begin
         errors++; $display("FAIL full_stale got %0d/%h exp 5/80", ret_rdidx, ret_pc);
      end
   endtask

   task automatic test_match();
      do_reset();
      dis_ena = 1; disp_i_rdidx = 7; disp_i_rdwen = 1; disp_i_pc = 32'h100;
      step();
      dis_ena = 0; disp_i_rdwen = 1; disp_i_rdidx = 4;
      disp_i_rs1en = 1; disp_i_rs1idx = 3;
      disp_i_rs2en = 1; disp_i_rs2idx = 7;
      disp_i_rs3en = 1; disp_i_rs3idx = 8;
      #1;
      checks++;
      if (mt !== 4'b0100) begin errors++; $display("FAIL match_rs2 got %b exp 0100", mt); end
      disp_i_rs2en = 0; #1;
      checks++;
      if (mt !== 4'b0000) begin errors++; $display("FAIL match_rs2_dis got %b exp 0000", mt); end
      disp_i_rdidx = 7; disp_i_rs1idx = 7; disp_i_rs1fpu = 1; #1;
      checks++;
      if (mt !== 4'b1001) begin errors++; $display("FAIL match_rd_rs1 got %b exp 1001", mt); end
      disp_i_rdwen = 0; #1;
      checks++;
      if (mt !== 4'b1000) begin errors++; $display("FAIL match_rd_dis got %b exp 1000", mt); end
      // same-cycle allocation must not hit
      disp_i_rs1en = 0; dis_ena = 1; disp_i_rdwen = 1; disp_i_rdidx = 12;
      disp_i_rs3idx = 12; #1;
      checks++;
      if (mt !== 4'b0000) begin errors++; $display("FAIL match_same_cycle got %b exp 0000", mt); end
      step();
      dis_ena = 0; disp_i_rdwen = 0; #1;
      checks++;
      if (mt !== 4'b0010) begin errors++; $display("FAIL match_next_cycle got %b exp 0010", mt); end
      // rdwen=0 entry never matches
      clr_inputs(); do_reset();
      dis_ena = 1; disp_i_rdidx = 9; disp_i_rdwen = 0;
      step();
      dis_ena = 0; disp_i_rs1en = 1; disp_i_rs1idx = 9; #1;
      checks++;
      if (mt !== 4'b0000) begin errors++; $display("FAIL match_nowen got %b exp 0000", mt); end
      // retired entry no longer matches
      clr_inputs(); do_reset();
      dis_ena = 1; disp_i_rdidx = 7; disp_i_rdwen = 1;
      step();
      dis_ena = 0; ret_ena = 1;
      step();
      ret_ena = 0; disp_i_rs2en = 1; disp_i_rs2idx = 7; #1;
      checks++;
      if (mt !== 4'b0000) begin errors++; $display("FAIL match_retired got %b exp 0000", mt); end
      clr_inputs();
   endtask

   task automatic test_wrap();
      logic [0:0] exp_p;
      do_reset();
      for (int i = 0; i < 5; i++) begin
         exp_p = 1'(i % 2);
         dis_ena = 1; disp_i_rdidx = 5'(i + 1); disp_i_rdwen = 1; disp_i_pc = 32'(i * 4);
         step();
         dis_ena = 0; ret_ena = 1;
         checks++;
         if ({ret_ptr, ret_rdidx} !== {exp_p, 5'(i + 1)}) begin
            errors++; $display("FAIL wrap_%0d got ptr %0d idx %0d exp %0d %0d", i, ret_ptr, ret_rdidx, exp_p, i + 1);
         end
         step();
         ret_ena = 0;
      end
      checks++;
      if (st !== 4'b1111) begin errors++; $display("FAIL wrap_end got %b exp 1111", st); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      dis_ena = 1; disp_i_rdidx = 1; disp_i_rdwen = 1; disp_i_pc = 32'h10;
      step();
      ret_ena = 1; disp_i_rdidx = 2; disp_i_pc = 32'h14;
      step();
      checks++;
      if (st !== 4'b0101) begin errors++; $display("FAIL b2b_status got %b exp 0101", st); end
      checks++;
      if ({ret_rdidx, ret_pc} !== {5'd2, 32'h14}) begin
         errors++; $display("FAIL b2b_head got %0d/%h exp 2/14", ret_rdidx, ret_pc);
      end
      dis_ena = 0;
      step();
      ret_ena = 0;
      checks++;
      if (st !== 4'b1100) begin errors++; $display("FAIL b2b_drain got %b exp 1100", st); end
   endtask

   task automatic test_empty_retire();
      do_reset();
      ret_ena = 1;
      step();
      checks++;
      if (st !== 4'b1100) begin errors++; $display("FAIL empty_ret got %b exp 1100", st); end
      dis_ena = 1; disp_i_rdidx = 3; disp_i_rdwen = 1; disp_i_pc = 32'h40;
      step();
      dis_ena = 0; ret_ena = 0;
      checks++;
      if (st !== 4'b0110) begin errors++; $display("FAIL empty_ret_alloc got %b exp 0110", st); end
      checks++;
      if ({ret_rdidx, ret_pc} !== {5'd3, 32'h40}) begin
         errors++; $display("FAIL empty_ret_payload got %0d/%h exp 3/40", ret_rdidx, ret_pc);
      end
   endtask

   task automatic test_reset_midway();
      do_reset();
      dis_ena = 1; disp_i_rdidx = 11; disp_i_rdwen = 1; disp_i_pc = 32'hABC;
      step();
      rst_n = 0; dis_ena = 1; ret_ena = 0;
      step();
      rst_n = 1; dis_ena = 0;
      disp_i_rs1en = 1; disp_i_rs1idx = 11; disp_i_rdidx = 11; #1;
      checks++;
      if (st !== 4'b1100) begin errors++; $display("FAIL midrst_status got %b exp 1100", st); end
      checks++;
      if ({ret_rdidx, ret_rdwen, ret_rdfpu, ret_pc} !== 39'h0) begin
         errors++; $display("FAIL midrst_payload got %h exp 0", {ret_rdidx, ret_rdwen, ret_rdfpu, ret_pc});
      end
      checks++;
      if (mt !== 4'b0000) begin errors++; $display("FAIL midrst_match got %b exp 0000", mt); end
      clr_inputs();
   endtask

   initial begin
      clr_inputs();
      rst_n = 0;
      test_reset();
      test_alloc();
      test_full();
      test_match();
      test_wrap();
      test_back_to_back();
      test_empty_retire();
      test_reset_midway();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
